// File: rtl/input_port_rx_if.sv
// Bundles the network-side packet/credit signals and the user-side word handshake of one input port.
// master: the receive endpoint (drives credits and user words); slave: the network/user environment.
// Widths follow the endpoint parameters; instantiate with matching values.
interface input_port_rx_if #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int PAYLOAD_BITS  = 64
);
  logic [PACKET_BITS-1:0]   internal_in;
  logic [NUM_LEAF_BITS-1:0] resp_leaf;
  logic [NUM_PORT_BITS-1:0] resp_port;
  logic [PACKET_BITS-1:0]   credit_out;
  logic                     credit_vld;
  logic                     credit_ack;
  logic [PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic                     vld_interface2user;
  logic                     ack_user2interface;

  modport master (
    input  internal_in, resp_leaf, resp_port, credit_ack, ack_user2interface,
    output credit_out, credit_vld, dout_leaf_interface2user, vld_interface2user
  );

  modport slave (
    output internal_in, resp_leaf, resp_port, credit_ack, ack_user2interface,
    input  credit_out, credit_vld, dout_leaf_interface2user, vld_interface2user
  );
endinterface

// File: rtl/input_port_rx.sv
// Input-port receive endpoint: slot-addressed reorder buffer, in-order user delivery, credit return.
// Latency: packet at the read pointer sampled at edge N is presented to the user after edge N+2.
// Backpressure: a 2-entry skid stalls reads while the user withholds ack; credits wait for credit_ack.
// Optional INPUT_PORT_STATS_EN adds input_port_empty_cnt (cycles with no word presented).
module input_port_rx #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input_port_rx_if.master   bus,
  output logic              overflow_err,
  input  logic              is_done_mode
`ifdef INPUT_PORT_STATS_EN
  ,
  output logic [PAYLOAD_BITS-1:0] input_port_empty_cnt
`endif
);

  localparam int DEPTH = 1 << NUM_ADDR_BITS;
  localparam logic [NUM_ADDR_BITS:0]   CREDIT_AMT = (NUM_ADDR_BITS+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_ADDR_BITS:0]   CNT_LAST   = (NUM_ADDR_BITS+1)'(FREESPACE_UPDATE_SIZE - 1);
  localparam logic [NUM_ADDR_BITS-1:0] PEND_MAX   = '1;

  logic                      wr_vld;
  logic [NUM_ADDR_BITS-1:0]  wr_slot;
  logic [PAYLOAD_BITS-1:0]   wr_dat;
  logic                      wr_ok;
  logic                      unused_pkt_bits;

  logic [PAYLOAD_BITS-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]          occ;
  logic [NUM_ADDR_BITS-1:0]  rd_ptr;
  logic                      rd_en;
  logic                      rd_inflight;
  logic [PAYLOAD_BITS-1:0]   rd_data;

  logic [PAYLOAD_BITS-1:0]   skid_dat [2];
  logic [1:0]                skid_cnt;
  logic                      hs;

  logic [NUM_ADDR_BITS:0]    consumed_cnt;
  logic [NUM_ADDR_BITS-1:0]  pending;
  logic                      credit_inc;
  logic                      credit_dec;

  assign wr_vld          = bus.internal_in[PACKET_BITS-1];
  assign wr_slot         = bus.internal_in[NUM_ADDR_BITS+PAYLOAD_BITS-1:PAYLOAD_BITS];
  assign wr_dat          = bus.internal_in[PAYLOAD_BITS-1:0];
  assign unused_pkt_bits = ^bus.internal_in[PACKET_BITS-2:NUM_ADDR_BITS+PAYLOAD_BITS];

  // A read only issues on an occupied slot, so a write hitting the slot being
  // read-cleared this cycle still sees occ set and is dropped as an overflow.
  assign wr_ok = wr_vld && !occ[wr_slot];

  assign hs    = bus.vld_interface2user && bus.ack_user2interface;
  assign rd_en = occ[rd_ptr] && (((skid_cnt + {1'b0, rd_inflight}) < 2'd2) || hs);

  assign bus.vld_interface2user       = (skid_cnt != 2'd0);
  assign bus.dout_leaf_interface2user = skid_dat[0];

  assign credit_inc     = hs && (consumed_cnt == CNT_LAST);
  assign credit_dec     = bus.credit_vld && bus.credit_ack;
  assign bus.credit_vld = (pending != '0);

  // Occupancy bitmap, read pointer, in-flight read flag and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ          <= '0;
      rd_ptr       <= '0;
      rd_inflight  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_ok) occ[wr_slot] <= 1'b1;
      if (rd_en) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      rd_inflight <= rd_en;
      if (wr_vld && !wr_ok) overflow_err <= 1'b1;
    end
  end

  // Payload storage with a registered read port; contents are qualified by occ, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_slot] <= wr_dat;
    if (rd_en) rd_data <= mem[rd_ptr];
  end

  // Two-entry skid: absorbs the in-flight read when the user stops acking; entry 0 is the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_dat[0] <= '0;
      skid_dat[1] <= '0;
      skid_cnt    <= 2'd0;
    end else begin
      case ({rd_inflight, hs})
        2'b10: begin
          skid_dat[skid_cnt[0]] <= rd_data;
          skid_cnt              <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_dat[0] <= skid_dat[1];
          skid_cnt    <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd2) begin
            skid_dat[0] <= skid_dat[1];
            skid_dat[1] <= rd_data;
          end else begin
            skid_dat[0] <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Consumption counter and saturating count of credit packets awaiting acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      consumed_cnt <= '0;
      pending      <= '0;
    end else begin
      if (hs) consumed_cnt <= credit_inc ? '0 : consumed_cnt + 1'b1;
      if (credit_inc && !credit_dec && (pending != PEND_MAX)) pending <= pending + 1'b1;
      else if (credit_dec && !credit_inc)                     pending <= pending - 1'b1;
    end
  end

  // Credit packet addressed back to the sender; carries a constant credit amount.
  always_comb begin
    bus.credit_out                                           = '0;
    bus.credit_out[PACKET_BITS-1]                            = 1'b1;
    bus.credit_out[PACKET_BITS-2 -: NUM_LEAF_BITS]           = bus.resp_leaf;
    bus.credit_out[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] = bus.resp_port;
    bus.credit_out[NUM_ADDR_BITS:0]                          = CREDIT_AMT;
  end

`ifdef INPUT_PORT_STATS_EN
  // Counts cycles with no word presented to the user, frozen once the run is done.
  always_ff @(posedge clk) begin
    if (reset) begin
      input_port_empty_cnt <= '0;
    end else if (!bus.vld_interface2user && !is_done_mode) begin
      input_port_empty_cnt <= input_port_empty_cnt + 1'b1;
    end
  end
`else
  logic unused_done_mode;
  assign unused_done_mode = is_done_mode;
`endif

endmodule

// File: tb/tb_input_port_rx.sv
// Directed bench for input_port_rx: latency, reordering, streaming/wrap, backpressure, credits,
// overflow, mid-run reset and (with INPUT_PORT_STATS_EN) the empty-cycle counter.
module tb_input_port_rx;
  localparam int PACKET_BITS = 97;
  localparam int NL = 6;
  localparam int NP = 4;
  localparam int NA = 7;
  localparam int PB = 64;
  localparam int FS = 64;

  logic clk = 1'b0;
  logic reset;
  logic is_done_mode;
  logic overflow_err;
`ifdef INPUT_PORT_STATS_EN
  logic [PB-1:0] empty_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  input_port_rx_if #(.PACKET_BITS(PACKET_BITS), .NUM_LEAF_BITS(NL), .NUM_PORT_BITS(NP),
                     .PAYLOAD_BITS(PB)) bus ();

  input_port_rx #(
    .PACKET_BITS(PACKET_BITS), .NUM_LEAF_BITS(NL), .NUM_PORT_BITS(NP),
    .NUM_ADDR_BITS(NA), .PAYLOAD_BITS(PB), .FREESPACE_UPDATE_SIZE(FS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .overflow_err (overflow_err),
    .is_done_mode (is_done_mode)
`ifdef INPUT_PORT_STATS_EN
    ,
    .input_port_empty_cnt (empty_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PACKET_BITS-1:0] mk_pkt(input logic [NA-1:0] slot, input logic [PB-1:0] pay);
    logic [PACKET_BITS-1:0] p;
    p = '0;
    p[96] = 1'b1;
    p[70:64] = slot;
    p[63:0] = pay;
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.internal_in = '0;
    bus.ack_user2interface = 1'b0;
    bus.credit_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.vld_interface2user !== 1'b0 || bus.credit_vld !== 1'b0 || overflow_err !== 1'b0 ||
        bus.dout_leaf_interface2user !== 64'h0) begin
      failures++;
      $display("FAIL reset_state: vld=%b credit_vld=%b ovf=%b dout=%h, want 0 0 0 0",
               bus.vld_interface2user, bus.credit_vld, overflow_err, bus.dout_leaf_interface2user);
    end
`ifdef INPUT_PORT_STATS_EN
    checks++;
    if (empty_cnt !== 64'd0) begin
      failures++;
      $display("FAIL reset_empty_cnt: got %0d want 0", empty_cnt);
    end
`endif
    // Acks with nothing presented must not count as consumption.
    bus.ack_user2interface = 1'b1;
    for (int i = 0; i < 70; i++) step();
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.credit_vld !== 1'b0 || bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack_ignored: credit_vld=%b vld=%b, want 0 0", bus.credit_vld, bus.vld_interface2user);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step();
    step();
    bus.internal_in = mk_pkt(7'd0, 64'hA5);
    step();
    bus.internal_in = '0;
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL basic_vld_n0: got %b want 0", bus.vld_interface2user);
    end
    step();
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL basic_vld_n1: got %b want 0", bus.vld_interface2user);
    end
    step();
    checks++;
    if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'hA5) begin
      failures++;
      $display("FAIL basic_vld_n2: vld=%b dout=%h, want 1 a5", bus.vld_interface2user, bus.dout_leaf_interface2user);
    end
    bus.ack_user2interface = 1'b1;
    step();
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_ack: vld=%b want 0", bus.vld_interface2user);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    bus.internal_in = mk_pkt(7'd1, 64'h11);
    step();
    bus.internal_in = '0;
    bus.ack_user2interface = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL ooo_hold: vld=%b want 0 before slot 0 arrives", bus.vld_interface2user);
    end
    bus.internal_in = mk_pkt(7'd0, 64'h00);
    step();
    bus.internal_in = '0;
    step();
    step();
    checks++;
    if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h00) begin
      failures++;
      $display("FAIL ooo_first: vld=%b dout=%h, want 1 0", bus.vld_interface2user, bus.dout_leaf_interface2user);
    end
    bus.ack_user2interface = 1'b1;
    step();
    checks++;
    if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h11) begin
      failures++;
      $display("FAIL ooo_second: vld=%b dout=%h, want 1 11", bus.vld_interface2user, bus.dout_leaf_interface2user);
    end
    step();
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      failures++;
      $display("FAIL ooo_drain: vld=%b want 0", bus.vld_interface2user);
    end
  endtask

  task automatic test_stream_wrap();
    logic [PB-1:0] exp;
    do_reset();
    bus.ack_user2interface = 1'b1;
    for (int k = 0; k < 202; k++) begin
      if (k < 200) bus.internal_in = mk_pkt(NA'(k % 128), 64'h1000 + 64'(k));
      else bus.internal_in = '0;
      step();
      checks++;
      if (k < 2) begin
        if (bus.vld_interface2user !== 1'b0) begin
          failures++;
          $display("FAIL stream_lead k=%0d: vld=%b want 0", k, bus.vld_interface2user);
        end
      end else begin
        exp = 64'h1000 + 64'(k - 2);
        if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== exp) begin
          failures++;
          $display("FAIL stream_word k=%0d: vld=%b dout=%h, want 1 %h", k, bus.vld_interface2user,
                   bus.dout_leaf_interface2user, exp);
        end
      end
    end
    step();
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.vld_interface2user !== 1'b0 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: vld=%b ovf=%b, want 0 0", bus.vld_interface2user, overflow_err);
    end
  endtask

  task automatic test_mid_reset();
    // 200 consumptions left three credits pending; a reset must discard them and stored data.
    checks++;
    if (bus.credit_vld !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_credit: credit_vld=%b want 1", bus.credit_vld);
    end
    bus.internal_in = mk_pkt(7'd72, 64'h77);
    step();
    bus.internal_in = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.vld_interface2user !== 1'b0 || bus.credit_vld !== 1'b0) begin
      failures++;
      $display("FAIL midrst_cleared: vld=%b credit_vld=%b, want 0 0", bus.vld_interface2user, bus.credit_vld);
    end
  endtask

  task automatic test_backpressure_credits();
    logic [PACKET_BITS-1:0] exp_credit;
    logic [PB-1:0] exp;
    logic exp_cv;
    exp_credit = '0;
    exp_credit[96] = 1'b1;
    exp_credit[95:90] = 6'h2A;
    exp_credit[89:86] = 4'h5;
    exp_credit[7:0] = 8'd64;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      bus.internal_in = mk_pkt(NA'(i), 64'h2000 + 64'(i));
      step();
    end
    bus.internal_in = '0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h2000 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_head: vld=%b dout=%h ovf=%b, want 1 2000 0", bus.vld_interface2user,
               bus.dout_leaf_interface2user, overflow_err);
    end
    bus.ack_user2interface = 1'b1;
    for (int j = 0; j < 128; j++) begin
      exp = 64'h2000 + 64'(j);
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== exp) begin
        failures++;
        $display("FAIL bp_word j=%0d: vld=%b dout=%h, want 1 %h", j, bus.vld_interface2user,
                 bus.dout_leaf_interface2user, exp);
      end
      step();
      exp_cv = (j >= 63);
      checks++;
      if (bus.credit_vld !== exp_cv) begin
        failures++;
        $display("FAIL bp_credit_vld j=%0d: got %b want %b", j, bus.credit_vld, exp_cv);
      end
      if (j == 63 || j == 127) begin
        checks++;
        if (bus.credit_out !== exp_credit) begin
          failures++;
          $display("FAIL bp_credit_out j=%0d: got %h want %h", j, bus.credit_out, exp_credit);
        end
      end
    end
    bus.ack_user2interface = 1'b0;
    step();
    checks++;
    if (bus.vld_interface2user !== 1'b0 || bus.credit_vld !== 1'b1) begin
      failures++;
      $display("FAIL bp_drained: vld=%b credit_vld=%b, want 0 1", bus.vld_interface2user, bus.credit_vld);
    end
    bus.credit_ack = 1'b1;
    step();
    checks++;
    if (bus.credit_vld !== 1'b1) begin
      failures++;
      $display("FAIL bp_pending_two: credit_vld=%b after one ack, want 1", bus.credit_vld);
    end
    step();
    bus.credit_ack = 1'b0;
    checks++;
    if (bus.credit_vld !== 1'b0) begin
      failures++;
      $display("FAIL bp_pending_zero: credit_vld=%b after two acks, want 0", bus.credit_vld);
    end
  endtask

  task automatic test_overflow();
    logic [PB-1:0] exp_words [4];
    exp_words[0] = 64'h0;
    exp_words[1] = 64'h1;
    exp_words[2] = 64'h2;
    exp_words[3] = 64'h33;
    do_reset();
    bus.internal_in = mk_pkt(7'd3, 64'h33);
    step();
    checks++;
    if (overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first: got %b want 0", overflow_err);
    end
    bus.internal_in = mk_pkt(7'd3, 64'h44);
    step();
    checks++;
    if (overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_second: got %b want 1", overflow_err);
    end
    for (int i = 0; i < 3; i++) begin
      bus.internal_in = mk_pkt(NA'(i), 64'(i));
      step();
    end
    bus.internal_in = '0;
    for (int i = 0; i < 5; i++) step();
    bus.ack_user2interface = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== exp_words[j]) begin
        failures++;
        $display("FAIL ovf_word j=%0d: vld=%b dout=%h, want 1 %h", j, bus.vld_interface2user,
                 bus.dout_leaf_interface2user, exp_words[j]);
      end
      step();
    end
    bus.ack_user2interface = 1'b0;
    checks++;
    if (bus.vld_interface2user !== 1'b0 || overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: vld=%b ovf=%b, want 0 1", bus.vld_interface2user, overflow_err);
    end
  endtask

`ifdef INPUT_PORT_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (empty_cnt !== 64'd10) begin
      failures++;
      $display("FAIL stats_idle: got %0d want 10", empty_cnt);
    end
    is_done_mode = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (empty_cnt !== 64'd10) begin
      failures++;
      $display("FAIL stats_frozen: got %0d want 10", empty_cnt);
    end
    is_done_mode = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    is_done_mode = 1'b0;
    bus.internal_in = '0;
    bus.resp_leaf = 6'h2A;
    bus.resp_port = 4'h5;
    bus.credit_ack = 1'b0;
    bus.ack_user2interface = 1'b0;
    test_reset();
    test_basic();
    test_out_of_order();
    test_stream_wrap();
    test_mid_reset();
    test_backpressure_credits();
    test_overflow();
`ifdef INPUT_PORT_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
